// File: rtl/gate_response_checker.sv
// Response checker for a 2-input gate under test.
// Tracks pattern coverage, mismatches and the first failing vector.
module gate_response_checker #(
  parameter int FUNC  = 0,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sample_valid,
  input  logic             data_1,
  input  logic             data_2,
  input  logic             data_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] err_count,
  output logic [3:0]       coverage,
  output logic             first_fail_valid,
  output logic [1:0]       first_fail_vec
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] vec_q, vec_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [3:0]       cov_q, cov_d;
  logic             ffv_q, ffv_d;
  logic [1:0]       ffvec_q, ffvec_d;

  logic       exp_out;
  logic [1:0] pat;
  logic [3:0] cov_nxt;

  // Expected gate output for the configured function
  always_comb begin
    exp_out = data_1 & data_2;
    case (FUNC)
      1:       exp_out = data_1 | data_2;
      2:       exp_out = data_1 ^ data_2;
      3:       exp_out = ~(data_1 & data_2);
      default: exp_out = data_1 & data_2;
    endcase
  end

  assign pat     = {data_1, data_2};
  assign cov_nxt = cov_q | (4'b0001 << pat);

  // Next-state and bookkeeping updates
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    err_d   = err_q;
    cov_d   = cov_q;
    ffv_d   = ffv_q;
    ffvec_d = ffvec_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          vec_d   = '0;
          err_d   = '0;
          cov_d   = 4'h0;
          ffv_d   = 1'b0;
          ffvec_d = 2'b00;
        end
      end
      S_RUN: begin
        if (sample_valid) begin
          if (vec_q != CNT_MAX) vec_d = vec_q + CNT_ONE;
          cov_d = cov_nxt;
          if (data_out != exp_out) begin
            if (err_q != CNT_MAX) err_d = err_q + CNT_ONE;
            if (!ffv_q) begin
              ffv_d   = 1'b1;
              ffvec_d = pat;
            end
          end
          if (cov_nxt == 4'hF) state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      vec_q   <= '0;
      err_q   <= '0;
      cov_q   <= 4'h0;
      ffv_q   <= 1'b0;
      ffvec_q <= 2'b00;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      err_q   <= err_d;
      cov_q   <= cov_d;
      ffv_q   <= ffv_d;
      ffvec_q <= ffvec_d;
    end
  end

  assign busy             = (state_q == S_RUN);
  assign done             = (state_q == S_DONE);
  assign pass             = done && (err_q == '0);
  assign vec_count        = vec_q;
  assign err_count        = err_q;
  assign coverage         = cov_q;
  assign first_fail_valid = ffv_q;
  assign first_fail_vec   = ffvec_q;

endmodule
